// File: rtl/skeeball_game_ctrl.sv
// skeeball_game_ctrl
//   Game sequencer for the skeeball cabinet. It synchronizes the raw start
//   button and the seven target sensors, debounces the sensors, counts balls
//   per game, and drives the score datapath. Each ball produces exactly one
//   one-hot award on `points`, which is followed one cycle later by a `ballclk`
//   commit strobe. Each new game clears the score: `playstate` is held low
//   while a clear commit strobe is issued.
//
// Ports
//   clk         system clock; all logic runs on posedge
//   rst_n       asynchronous active-low reset
//   start       raw start button (asynchronous)
//   sen[6:0]    raw target sensors: 100,50,40,30,20,10,gutter (MSB..LSB)
//   playstate   0 clears the score block, 1 lets it play or hold the score
//   points[6:0] one-hot award for the current ball, same bit order as sen
//   ballclk     score commit strobe (the score block commits on its falling edge)
//   balls_left  balls remaining in the current game
//   game_over   high while the game is over and waiting for start
//
// Pipeline: both input paths are three flops deep (2-flop synchronizer
// followed by one more register), and every output is registered from the
// current state. Each output therefore shows the state one cycle after the
// state register holds it.
module skeeball_game_ctrl #(
    parameter int NUM_BALLS = 9,
    parameter int DEBOUNCE  = 3,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] sen,
    output logic       playstate,
    output logic [6:0] points,
    output logic       ballclk,
    output logic [3:0] balls_left,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_CLR_CMT, S_WAIT_BALL,
        S_SCORE, S_COMMIT, S_SETTLE, S_GAME_OVER
    } state_t;

    localparam logic [3:0]  DB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  BALLS   = 4'(NUM_BALLS);

    // Input synchronizers and the registered edge/sample stage.
    logic [6:0] sen_s1_q, sen_s2_q, sen_r_q;
    logic       st_s1_q, st_s2_q, st_prev_q, st_rise_q;

    state_t      state_q, state_d;
    logic [3:0]  db_cnt_q, db_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [6:0]  capture_q, capture_d;

    logic       playstate_q, playstate_d;
    logic [6:0] points_q, points_d;
    logic       ballclk_q, ballclk_d;
    logic [3:0] balls_left_q, balls_left_d;
    logic       game_over_q, game_over_d;

    logic s_any;
    assign s_any = |sen_r_q;

    // The highest-value active sensor wins. The loop runs upward, so a later
    // (higher) bit overwrites a lower one.
    function automatic logic [6:0] top_bit(input logic [6:0] v);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        to_cnt_d  = to_cnt_q;
        capture_d = capture_q;
        case (state_q)
            S_IDLE:      if (st_rise_q) state_d = S_CLR;
            S_CLR:       state_d = S_CLR_CMT;
            S_CLR_CMT: begin
                state_d  = S_WAIT_BALL;
                db_cnt_d = '0;
                to_cnt_d = '0;
            end
            S_WAIT_BALL: begin
                // A hit takes priority over a timeout that expires on the same cycle.
                if (s_any && db_cnt_q == DB_LAST) begin
                    capture_d = top_bit(sen_r_q);
                    state_d   = S_SCORE;
                    db_cnt_d  = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    capture_d = 7'b0000001;
                    state_d   = S_SCORE;
                    db_cnt_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                    db_cnt_d = s_any ? db_cnt_q + 4'd1 : 4'd0;
                end
            end
            S_SCORE:     state_d = S_COMMIT;
            S_COMMIT:    state_d = S_SETTLE;
            S_SETTLE: begin
                // Here the counter measures quiet time, so a ball still
                // resting on a sensor cannot score twice.
                if (!s_any && db_cnt_q == DB_LAST) begin
                    db_cnt_d = '0;
                    to_cnt_d = '0;
                    state_d  = (balls_left_q == 4'd0) ? S_GAME_OVER : S_WAIT_BALL;
                end else begin
                    db_cnt_d = s_any ? 4'd0 : db_cnt_q + 4'd1;
                end
            end
            S_GAME_OVER: if (st_rise_q) state_d = S_CLR;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        playstate_d  = !(state_q == S_IDLE || state_q == S_CLR || state_q == S_CLR_CMT);
        points_d     = (state_q == S_SCORE) ? capture_q : 7'd0;
        ballclk_d    = (state_q == S_CLR_CMT) || (state_q == S_COMMIT);
        game_over_d  = (state_q == S_GAME_OVER);
        balls_left_d = balls_left_q;
        if (state_q == S_CLR_CMT)
            balls_left_d = BALLS;
        else if (state_q == S_COMMIT && balls_left_q != 4'd0)
            balls_left_d = balls_left_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sen_s1_q     <= '0;
            sen_s2_q     <= '0;
            sen_r_q      <= '0;
            st_s1_q      <= 1'b0;
            st_s2_q      <= 1'b0;
            st_prev_q    <= 1'b0;
            st_rise_q    <= 1'b0;
            state_q      <= S_IDLE;
            db_cnt_q     <= '0;
            to_cnt_q     <= '0;
            capture_q    <= '0;
            playstate_q  <= 1'b0;
            points_q     <= '0;
            ballclk_q    <= 1'b0;
            balls_left_q <= '0;
            game_over_q  <= 1'b0;
        end else begin
            sen_s1_q     <= sen;
            sen_s2_q     <= sen_s1_q;
            sen_r_q      <= sen_s2_q;
            st_s1_q      <= start;
            st_s2_q      <= st_s1_q;
            st_prev_q    <= st_s2_q;
            st_rise_q    <= st_s2_q & ~st_prev_q;
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            to_cnt_q     <= to_cnt_d;
            capture_q    <= capture_d;
            playstate_q  <= playstate_d;
            points_q     <= points_d;
            ballclk_q    <= ballclk_d;
            balls_left_q <= balls_left_d;
            game_over_q  <= game_over_d;
        end
    end

    assign playstate  = playstate_q;
    assign points     = points_q;
    assign ballclk    = ballclk_q;
    assign balls_left = balls_left_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// Bench for skeeball_game_ctrl (NUM_BALLS=9, DEBOUNCE=3, TIMEOUT=20).
// A monitor records every points/ballclk pulse together with its cycle
// number. The directed and randomized balls are then compared against an
// award model: the highest active sensor, or the gutter when no sensor fires.
module tb_skeeball_game_ctrl;

    localparam int NB = 9;
    localparam int DB = 3;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] sen;
    logic       playstate;
    logic [6:0] points;
    logic       ballclk;
    logic [3:0] balls_left;
    logic       game_over;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int bl_exp = 0;

    logic [6:0] exp_q[$];
    logic [6:0] pts_q[$];
    int         pts_cyc_q[$];
    int         bc_cyc_q[$];

    skeeball_game_ctrl #(.NUM_BALLS(NB), .DEBOUNCE(DB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sen(sen),
        .playstate(playstate), .points(points), .ballclk(ballclk),
        .balls_left(balls_left), .game_over(game_over)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- pulse monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (points != 7'd0) begin
                pts_q.push_back(points);
                pts_cyc_q.push_back(cyc);
            end
            if (ballclk) bc_cyc_q.push_back(cyc);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] award_of(input logic [6:0] mask);
        int k;
        if (mask == 7'd0) return 7'd1;
        k = $clog2(int'(mask) + 1) - 1;
        return 7'(1 << k);
    endfunction

    task automatic clear_mon();
        pts_q.delete();
        pts_cyc_q.delete();
        bc_cyc_q.delete();
    endtask

    // Press start and check the clear sequence: CLR keeps playstate low, and
    // the clear commit strobe loads the ball count.
    task automatic do_start(input string tag);
        start = 1'b1;
        repeat (5) tick();
        check({tag, "_ps_clr"}, playstate, 0);
        check({tag, "_bc_early"}, ballclk, 0);
        tick();
        check({tag, "_bc"}, ballclk, 1);
        check({tag, "_bl"}, balls_left, NB);
        check({tag, "_go"}, game_over, 0);
        tick();
        check({tag, "_bc_end"}, ballclk, 0);
        check({tag, "_ps_play"}, playstate, 1);
        start = 1'b0;
        bl_exp = NB;
    endtask

    // Play one ball. A zero mask means no sensor activity, so the ball ends
    // as a gutter via the timeout.
    task automatic play_ball(input logic [6:0] mask, input int hold, input string tag);
        int t0;
        logic [6:0] exp;
        clear_mon();
        exp_q.push_back(award_of(mask));
        t0 = cyc;
        if (mask != 7'd0) begin
            sen = mask;
            repeat (hold) tick();
            sen = 7'd0;
        end
        for (int k = 0; k < 80 && bc_cyc_q.size() == 0; k++) tick();
        check({tag, "_bc_seen"}, bc_cyc_q.size(), 1);
        exp = exp_q.pop_front();
        check({tag, "_npts"}, pts_q.size(), 1);
        if (pts_q.size() > 0) begin
            check({tag, "_val"}, pts_q[0], exp);
            if (bc_cyc_q.size() > 0)
                check({tag, "_gap"}, bc_cyc_q[0] - pts_cyc_q[0], 1);
            if (mask != 7'd0)
                check({tag, "_lat"}, pts_cyc_q[0] - t0, DB + 4);
        end
        tick();
        bl_exp--;
        check({tag, "_bl"}, balls_left, bl_exp);
        repeat (10) tick();
        check({tag, "_extra"}, pts_q.size() + bc_cyc_q.size(), 2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] m;
        rst_n = 1'b0;
        start = 1'b0;
        sen   = 7'd0;
        repeat (3) tick();
        check("rst_ps", playstate, 0);
        check("rst_pts", points, 0);
        check("rst_bc", ballclk, 0);
        check("rst_bl", balls_left, 0);
        check("rst_go", game_over, 0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("idle_ps", playstate, 0);

        // Game 1
        do_start("start1");
        play_ball(7'b0000010, 8, "b1_ten");
        // A glitch shorter than the debounce window must not score.
        sen = 7'b0100000;
        repeat (2) tick();
        sen = 7'd0;
        repeat (2) tick();
        check("b2_glitch_bl", balls_left, bl_exp);
        play_ball(7'b0100000, 5, "b2_fifty");
        play_ball(7'b1000100, 4, "b3_prio");
        play_ball(7'b0000000, 0, "b4_gutter");
        for (int b = 5; b <= NB; b++) begin
            m = 7'($urandom_range(0, 127));
            play_ball(m, $urandom_range(DB, 8), $sformatf("g1_b%0d", b));
        end
        check("g1_over", game_over, 1);
        check("g1_ps", playstate, 1);
        check("g1_bl", balls_left, 0);

        // Game 2: reset during the settle phase of ball 4
        do_start("start2");
        for (int b = 1; b <= 3; b++) begin
            m = 7'($urandom_range(1, 127));
            play_ball(m, $urandom_range(DB, 8), $sformatf("g2_b%0d", b));
        end
        clear_mon();
        sen = 7'($urandom_range(1, 127));
        repeat (11) tick();
        check("g2_b4_commit", bc_cyc_q.size(), 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_ps", playstate, 0);
        check("mid_rst_pts", points, 0);
        check("mid_rst_bc", ballclk, 0);
        check("mid_rst_bl", balls_left, 0);
        check("mid_rst_go", game_over, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        for (int k = 0; k < 30; k++) begin
            sen = 7'($urandom);
            tick();
        end
        sen = 7'd0;
        repeat (5) tick();
        check("post_rst_pulses", pts_q.size() + bc_cyc_q.size(), 0);
        check("post_rst_bl", balls_left, 0);
        check("post_rst_ps", playstate, 0);

        do_start("start3");
        m = 7'($urandom_range(1, 127));
        play_ball(m, $urandom_range(DB, 8), "g3_b1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
